// File: rtl/comb_delay_line_m256_if.sv
// Sample-in / comb-operand-out bundle for comb_delay_line_m256.
// The producer side uses master and the delay line uses slave.
interface comb_delay_line_m256_if #(
    parameter int IW = 24
);
    logic          s_valid;
    logic [IW-1:0] s_data;
    logic          m_valid;
    logic [47:0]   c;
    logic [47:0]   concat;
    logic          primed;

    modport master (
        output s_valid, s_data,
        input  m_valid, c, concat, primed
    );

    modport slave (
        input  s_valid, s_data,
        output m_valid, c, concat, primed
    );
endinterface

// File: rtl/comb_delay_line_m256.sv
// Differential-delay stage for the CIC comb: emits x[n] and x[n-DEPTH], both sign-extended to 48 bits.
// Optional synchronous history flush is enabled by defining COMB_DELAY_FLUSH_EN.
module comb_delay_line_m256 #(
    parameter int DEPTH = 256,
    parameter int IW    = 24
) (
    input  logic clk,
    input  logic rst_n,
`ifdef COMB_DELAY_FLUSH_EN
    input  logic flush,
`endif
    comb_delay_line_m256_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] prime_cnt;
    logic          primed_q;

    logic          flush_i;
    logic          accept;

    logic [IW-1:0] s1_rd;
    logic [IW-1:0] s1_cur;
    logic          s1_valid;
    logic          s1_zero;

    logic          m_valid_q;
    logic [47:0]   c_q;
    logic [47:0]   concat_q;

`ifdef COMB_DELAY_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // A flushed cycle neither writes history nor enters the pipeline.
    assign accept = bus.s_valid && !flush_i;

    function automatic logic [47:0] sext(input logic [IW-1:0] v);
        logic signed [IW-1:0] sv;
        sv = v;
        return 48'(sv);
    endfunction

    // Read-before-write on the same address; the RAM and read register carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_rd        <= mem[wr_ptr];
            mem[wr_ptr]  <= bus.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            prime_cnt <= '0;
            primed_q  <= 1'b0;
            s1_cur    <= '0;
            s1_valid  <= 1'b0;
            s1_zero   <= 1'b1;
        end else if (flush_i) begin
            wr_ptr    <= '0;
            prime_cnt <= '0;
            primed_q  <= 1'b0;
            s1_valid  <= 1'b0;
        end else begin
            s1_valid <= bus.s_valid;
            if (bus.s_valid) begin
                wr_ptr  <= wr_ptr + AW'(1);
                s1_cur  <= bus.s_data;
                s1_zero <= !primed_q;
                if (prime_cnt != CW'(DEPTH)) begin
                    prime_cnt <= prime_cnt + CW'(1);
                end
                if (prime_cnt == CW'(DEPTH - 1)) begin
                    primed_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            c_q       <= '0;
            concat_q  <= '0;
        end else if (flush_i) begin
            m_valid_q <= 1'b0;
        end else begin
            m_valid_q <= s1_valid;
            if (s1_valid) begin
                c_q      <= sext(s1_cur);
                concat_q <= s1_zero ? 48'd0 : sext(s1_rd);
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.c       = c_q;
    assign bus.concat  = concat_q;
    assign bus.primed  = primed_q;

endmodule

// File: tb/tb_comb_delay_line_m256.sv
// Directed bench for comb_delay_line_m256 with a sample-history scoreboard.
module tb_comb_delay_line_m256;
    localparam int DEPTH = 256;
    localparam int IW    = 24;

    typedef struct packed {
        logic [47:0] c;
        logic [47:0] concat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t          sb[$];
    logic [IW-1:0] hist[$];

    logic        vd1 = 1'b0;
    logic        vd2 = 1'b0;
    int          acc = 0;
    logic [47:0] last_c = '0;
    logic [47:0] last_concat = '0;

    always #5 clk = ~clk;

    comb_delay_line_m256_if #(.IW(IW)) bus ();

    comb_delay_line_m256 #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef COMB_DELAY_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    function automatic logic [47:0] tb_sext(input logic [IW-1:0] d);
        return {{(48 - IW){d[IW-1]}}, d};
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk48(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference pipeline: valid delay, accept count, and dropping of the flushed in-flight sample.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vd1 <= 1'b0;
            vd2 <= 1'b0;
            acc <= 0;
        end else if (flush === 1'b1) begin
            if (vd1) void'(sb.pop_back());
            vd1 <= 1'b0;
            vd2 <= 1'b0;
            acc <= 0;
        end else begin
            vd2 <= vd1;
            vd1 <= bus.s_valid;
            if (bus.s_valid) acc <= acc + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                last_c      = '0;
                last_concat = '0;
            end
            chk1("m_valid", bus.m_valid, vd2);
            if (bus.m_valid === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed m_valid=1 expected no output at %0t", $time);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e           = sb.pop_front();
                    last_c      = e.c;
                    last_concat = e.concat;
                end
            end
            chk48("c", bus.c, last_c);
            chk48("concat", bus.concat, last_concat);
            chk1("primed", bus.primed, acc >= DEPTH);
        end
    end

    task automatic drive(input logic v, input logic [IW-1:0] d);
        exp_t e;
        bus.s_valid = v;
        bus.s_data  = d;
        flush       = 1'b0;
        if (v) begin
            e.c      = tb_sext(d);
            e.concat = (hist.size() >= DEPTH) ? tb_sext(hist[hist.size() - DEPTH]) : 48'd0;
            sb.push_back(e);
            hist.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, IW'($urandom));
    endtask

    task automatic do_reset(input int n);
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        flush       = 1'b0;
        sb.delete();
        hist.delete();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        flush       = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst_n  = 1'b1;
        idle(2);

        // ramp 1..600 back to back
        do_reset(2);
        for (int n = 1; n <= 600; n++) drive(1'b1, IW'(n));
        idle(4);

        // same ramp with random gaps
        do_reset(2);
        begin
            int n;
            n = 1;
            while (n <= 600) begin
                if ($urandom_range(0, 1) == 1) begin
                    drive(1'b1, IW'(n));
                    n++;
                end else begin
                    drive(1'b0, IW'($urandom));
                end
            end
        end
        idle(4);

        // sign extension extremes, returned again as concat after DEPTH more samples
        do_reset(2);
        drive(1'b1, 24'h800000);
        drive(1'b1, 24'h7FFFFF);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, IW'($urandom));
        idle(4);

        // pointer wraps with random data
        do_reset(2);
        for (int i = 0; i < 3 * DEPTH + 5; i++) drive(1'b1, IW'($urandom));
        idle(4);

        // reset mid-stream, then a short restart
        do_reset(2);
        for (int n = 1; n <= 300; n++) drive(1'b1, IW'(n));
        do_reset(3);
        for (int n = 1; n <= 10; n++) drive(1'b1, IW'(n));
        idle(4);

`ifdef COMB_DELAY_FLUSH_EN
        // flush coincident with sample 400
        do_reset(2);
        for (int n = 1; n <= 399; n++) drive(1'b1, IW'(n));
        bus.s_valid = 1'b1;
        bus.s_data  = IW'(400);
        flush       = 1'b1;
        hist.delete();
        @(posedge clk);
        #1;
        for (int n = 401; n <= 700; n++) drive(1'b1, IW'(n));
        idle(4);
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
